// File: rtl/md_sequencer_if.sv
// Interface for the E-stage multiply/divide sequencer.
// It bundles the pipeline-side request and operand signals with the HI/LO result signals.
interface md_sequencer_if;
    logic        req;
    logic [3:0]  MD_op;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic [31:0] MD_out;

    modport master (
        output req, MD_op, start, A, B,
        input  busy, HI_out, LO_out, MD_out
    );

    modport slave (
        input  req, MD_op, start, A, B,
        output busy, HI_out, LO_out, MD_out
    );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency multiply/divide sequencer for the E stage. It owns HI/LO and serves mfhi/mflo/mthi/mtlo.
// The result is computed into shadow registers at launch and committed after the busy window.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      hi, hi_next, lo, lo_next;
    logic [31:0]      hi_s, hi_s_next, lo_s, lo_s_next;

    logic        busy;
    logic        accept;
    logic        is_md_op;
    logic [63:0] prod_s, prod_u;
    logic [31:0] divisor_u, a_mag, b_mag, divisor_mag;
    logic [31:0] quot_u, rem_u, q_mag, r_mag, quot_s, rem_s;

    assign busy     = (state != IDLE);
    assign is_md_op = (bus.MD_op >= OP_MULT) && (bus.MD_op <= OP_DIVU);
    assign accept   = bus.start && !bus.req && !busy && is_md_op;

    // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    // A zero divisor is replaced by 1 only to keep the dividers defined; that result is never committed.
    always_comb begin
        prod_u      = {32'd0, bus.A} * {32'd0, bus.B};
        prod_s      = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        divisor_u   = (bus.B == 32'd0) ? 32'd1 : bus.B;
        quot_u      = bus.A / divisor_u;
        rem_u       = bus.A % divisor_u;
        a_mag       = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
        b_mag       = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
        divisor_mag = (bus.B == 32'd0) ? 32'd1 : b_mag;
        q_mag       = a_mag / divisor_mag;
        r_mag       = a_mag % divisor_mag;
        quot_s      = (bus.A[31] ^ bus.B[31]) ? (~q_mag + 32'd1) : q_mag;
        rem_s       = bus.A[31] ? (~r_mag + 32'd1) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            hi_s  <= 32'd0;
            lo_s  <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            hi    <= hi_next;
            lo    <= lo_next;
            hi_s  <= hi_s_next;
            lo_s  <= lo_s_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hi_next    = hi;
        lo_next    = lo;
        hi_s_next  = hi_s;
        lo_s_next  = lo_s;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.MD_op)
                        OP_MULT: begin
                            {hi_s_next, lo_s_next} = prod_s;
                            state_next = MULT;
                            cnt_next   = MULT_LOAD;
                        end
                        OP_MULTU: begin
                            {hi_s_next, lo_s_next} = prod_u;
                            state_next = MULT;
                            cnt_next   = MULT_LOAD;
                        end
                        OP_DIV: begin
                            hi_s_next  = (bus.B == 32'd0) ? hi : rem_s;
                            lo_s_next  = (bus.B == 32'd0) ? lo : quot_s;
                            state_next = DIV;
                            cnt_next   = DIV_LOAD;
                        end
                        default: begin
                            hi_s_next  = (bus.B == 32'd0) ? hi : rem_u;
                            lo_s_next  = (bus.B == 32'd0) ? lo : quot_u;
                            state_next = DIV;
                            cnt_next   = DIV_LOAD;
                        end
                    endcase
                end else if (!bus.req && bus.MD_op == OP_MTHI) begin
                    hi_next = bus.A;
                end else if (!bus.req && bus.MD_op == OP_MTLO) begin
                    lo_next = bus.A;
                end
            end
            MULT, DIV: begin
                if (cnt == '0) begin
                    hi_next    = hi_s;
                    lo_next    = lo_s;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.MD_out = 32'd0;
        if (bus.MD_op == OP_MFHI) begin
            bus.MD_out = hi;
        end else if (bus.MD_op == OP_MFLO) begin
            bus.MD_out = lo;
        end
    end

    assign bus.busy   = busy;
    assign bus.HI_out = hi;
    assign bus.LO_out = lo;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: arithmetic results, busy window length, HI/LO moves, req and reset aborts.
module tb_md_sequencer;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    md_sequencer_if bus();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic st, input logic rq,
                                  input logic [31:0] a, input logic [31:0] b);
        bus.MD_op = op;
        bus.start = st;
        bus.req   = rq;
        bus.A     = a;
        bus.B     = b;
    endtask

    // Launch one operation, expect busy for exactly n cycles with HI/LO held, then the new result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        apply_stimulus(op, 1'b1, 1'b0, a, b);
        tick();
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= n; i++) begin
            check_output({tag, " busy"}, 32'(bus.busy), 32'd1);
            if (i == n) begin
                check_output({tag, " hi_held"}, bus.HI_out, cur_hi);
                check_output({tag, " lo_held"}, bus.LO_out, cur_lo);
            end
            tick();
        end
        check_output({tag, " idle"}, 32'(bus.busy), 32'd0);
        check_output({tag, " hi"}, bus.HI_out, exp_hi);
        check_output({tag, " lo"}, bus.LO_out, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset hi", bus.HI_out, 32'd0);
        check_output("reset lo", bus.LO_out, 32'd0);
        check_output("reset md_out", bus.MD_out, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("mult max", 4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op("mult m1", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001);
        run_op("multu m1", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu 100/7", 4'd4, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E);

        // Flushed launch and flushed mthi must leave everything untouched.
        apply_stimulus(4'd1, 1'b1, 1'b1, 32'd5, 32'd7);
        tick();
        check_output("req start busy", 32'(bus.busy), 32'd0);
        apply_stimulus(4'd7, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0);
        tick();
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_output("req busy", 32'(bus.busy), 32'd0);
        check_output("req hi", bus.HI_out, cur_hi);
        check_output("req lo", bus.LO_out, cur_lo);

        // mthi during an operation is dropped.
        apply_stimulus(4'd2, 1'b1, 1'b0, 32'd2, 32'd3);
        tick();
        apply_stimulus(4'd7, 1'b0, 1'b0, 32'h1234_5678, 32'd0);
        tick();
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_output("mthi busy hi", bus.HI_out, cur_hi);
        repeat (4) tick();
        check_output("mthi busy commit hi", bus.HI_out, 32'd0);
        check_output("mthi busy commit lo", bus.LO_out, 32'd6);

        apply_stimulus(4'd7, 1'b0, 1'b0, 32'h1234_5678, 32'd0);
        tick();
        check_output("mthi idle", bus.HI_out, 32'h1234_5678);
        apply_stimulus(4'd5, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_output("mfhi", bus.MD_out, 32'h1234_5678);
        apply_stimulus(4'd8, 1'b0, 1'b0, 32'hCAFE_F00D, 32'd0);
        tick();
        check_output("mtlo idle", bus.LO_out, 32'hCAFE_F00D);
        apply_stimulus(4'd6, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_output("mflo", bus.MD_out, 32'hCAFE_F00D);
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_output("md_out none", bus.MD_out, 32'd0);
        apply_stimulus(4'd15, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_output("md_out bad op", bus.MD_out, 32'd0);
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Reset in the third busy cycle of a divide aborts it for good.
        apply_stimulus(4'd3, 1'b1, 1'b0, 32'd100, 32'd7);
        tick();
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort busy", 32'(bus.busy), 32'd0);
        check_output("abort hi", bus.HI_out, 32'd0);
        check_output("abort lo", bus.LO_out, 32'd0);
        repeat (12) tick();
        check_output("abort late busy", 32'(bus.busy), 32'd0);
        check_output("abort late hi", bus.HI_out, 32'd0);
        check_output("abort late lo", bus.LO_out, 32'd0);

        // A start while busy is a hazard-unit violation; the running multu must finish unaffected.
        apply_stimulus(4'd2, 1'b1, 1'b0, 32'd2, 32'd3);
        tick();
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        $display("[TB] driving start while busy: hazard violation, relaunch must not happen");
        apply_stimulus(4'd3, 1'b1, 1'b0, 32'd100, 32'd7);
        tick();
        apply_stimulus(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        check_output("overlap last busy", 32'(bus.busy), 32'd1);
        tick();
        check_output("overlap idle", 32'(bus.busy), 32'd0);
        check_output("overlap hi", bus.HI_out, 32'd0);
        check_output("overlap lo", bus.LO_out, 32'd6);
        repeat (12) tick();
        check_output("overlap late busy", 32'(bus.busy), 32'd0);
        check_output("overlap late lo", bus.LO_out, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
